// File: rtl/accum_ctrl_pkg.sv
// Shared types and defaults for the accumulate sequencer.
// State encoding, entry width and default timing.
package accum_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int DEPTH_DEF  = 4;
  localparam int Y_W_DEF    = 4;
  localparam int ENT_W      = Y_W_DEF + 1;
  localparam int TO_CYC_DEF = 15;
  localparam int DROP_W_DEF = 8;

endpackage

// File: rtl/accum_evt_fifo.sv
// Small synchronous FIFO holding {dir, operand} detent entries.
// Occupancy carries one extra bit so full and empty differ.
module accum_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a pop frees the slot this same cycle, so a full push is allowed
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accum_seq_ctrl.sv
// Sequencer from rotary detents to the accumulate adder.
// Queues detents, issues req/ack ops, locks on overflow or stall.
module accum_seq_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int Y_W    = Y_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF,
  parameter int DROP_W = DROP_W_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rot_event,
  input  logic              rot_dir,
  input  logic [Y_W-1:0]    y,
  input  logic              clr,
  output logic              add_req,
  output logic              add_dir,
  output logic [Y_W-1:0]    add_opd,
  input  logic              add_ack,
  input  logic              add_ovf,
  output logic              acc_clr,
  output logic [CW-1:0]     pending,
  output logic              locked,
  output logic              timeout,
  output logic [DROP_W-1:0] dropped
);

  localparam int E_W = Y_W + 1;
  localparam int WW  = $clog2(TO_CYC + 1);

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [E_W-1:0] head;
  logic          full;
  logic          empty;
  logic          push_try;
  logic          push;
  logic          pop;
  logic          drop;
  logic          more;

  // clr outranks both a new detent and a completing ack
  assign push_try = rot_event & ~clr;
  assign pop      = (state == ST_REQ) & add_ack & ~clr;
  assign push     = push_try & (state != ST_LOCK);
  assign drop     = push_try & ((state == ST_LOCK) | (full & ~pop));
  assign more     = (pending > CW'(1)) | push;

  assign add_dir = add_req & head[E_W-1];
  assign add_opd = add_req ? head[Y_W-1:0] : '0;

  accum_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (E_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (clr),
    .din   ({rot_dir, y}),
    .dout  (head),
    .count (pending),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      add_req <= 1'b0;
      acc_clr <= 1'b0;
      locked  <= 1'b0;
      timeout <= 1'b0;
      dropped <= '0;
      wcnt    <= '0;
    end else if (clr) begin
      state   <= ST_IDLE;
      add_req <= 1'b0;
      acc_clr <= 1'b1;
      locked  <= 1'b0;
      timeout <= 1'b0;
      dropped <= '0;
      wcnt    <= '0;
    end else begin
      acc_clr <= 1'b0;
      if (drop && dropped != '1)
        dropped <= dropped + DROP_W'(1);
      unique case (state)
        ST_IDLE: begin
          // a same-cycle push lets req rise the cycle after the detent
          if (push || !empty) begin
            state   <= ST_REQ;
            add_req <= 1'b1;
            wcnt    <= '0;
          end
        end
        ST_REQ: begin
          if (add_ack) begin
            wcnt <= '0;
            if (add_ovf) begin
              locked  <= 1'b1;
              add_req <= 1'b0;
              state   <= ST_LOCK;
            end else if (!more) begin
              add_req <= 1'b0;
              state   <= ST_IDLE;
            end
          end else if (wcnt == WW'(TO_CYC - 1)) begin
            timeout <= 1'b1;
            add_req <= 1'b0;
            state   <= ST_LOCK;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        ST_LOCK: add_req <= 1'b0;
        default: begin
          state   <= ST_IDLE;
          add_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_accum_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rot_event;
  logic       rot_dir;
  logic [3:0] y;
  logic       clr;
  logic       add_req;
  logic       add_dir;
  logic [3:0] add_opd;
  logic       add_ack;
  logic       add_ovf;
  logic       acc_clr;
  logic [2:0] pending;
  logic       locked;
  logic       timeout;
  logic [7:0] dropped;

  int checks = 0;
  int errors = 0;

  accum_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rot_event (rot_event),
    .rot_dir   (rot_dir),
    .y         (y),
    .clr       (clr),
    .add_req   (add_req),
    .add_dir   (add_dir),
    .add_opd   (add_opd),
    .add_ack   (add_ack),
    .add_ovf   (add_ovf),
    .acc_clr   (acc_clr),
    .pending   (pending),
    .locked    (locked),
    .timeout   (timeout),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rot_event = 1'b0; rot_dir = 1'b0; y = '0;
    clr = 1'b0; add_ack = 1'b0; add_ovf = 1'b0;
    step(); step();
    check("rst_req", 32'(add_req), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_flags", 32'({locked, timeout, acc_clr}), 0);
    check("rst_drop", 32'(dropped), 0);
    rst_n = 1'b1;
    step();

    // single detent, ack two cycles after req rises
    rot_event = 1'b1; rot_dir = 1'b1; y = 4'd5;
    check("s_req0", 32'(add_req), 0);
    step(); rot_event = 1'b0;
    check("s_req1", 32'(add_req), 1);
    check("s_opd", 32'(add_opd), 5);
    check("s_dir", 32'(add_dir), 1);
    check("s_pend1", 32'(pending), 1);
    step();
    check("s_req2", 32'(add_req), 1);
    step();
    check("s_req3", 32'(add_req), 1);
    add_ack = 1'b1;
    step(); add_ack = 1'b0;
    check("s_req4", 32'(add_req), 0);
    check("s_pend0", 32'(pending), 0);

    // burst of six, two dropped, then drained in order
    for (int i = 0; i < 6; i++) begin
      rot_event = 1'b1; rot_dir = i[0]; y = 4'(i + 1);
      step();
    end
    rot_event = 1'b0;
    check("b_pend", 32'(pending), 4);
    check("b_drop", 32'(dropped), 2);
    for (int k = 0; k < 4; k++) begin
      check("b_req", 32'(add_req), 1);
      check("b_opd", 32'(add_opd), 32'(k + 1));
      check("b_dir", 32'(add_dir), 32'(k[0]));
      add_ack = 1'b1;
      step();
    end
    add_ack = 1'b0;
    check("b_idle", 32'(add_req), 0);
    check("b_pend0", 32'(pending), 0);

    // full FIFO with a coincident push and pop
    for (int i = 0; i < 4; i++) begin
      rot_event = 1'b1; rot_dir = 1'b1; y = 4'(7 + i);
      step();
    end
    rot_event = 1'b0;
    check("f_pend", 32'(pending), 4);
    check("f_head", 32'(add_opd), 7);
    rot_event = 1'b1; y = 4'd11; add_ack = 1'b1;
    step();
    rot_event = 1'b0; add_ack = 1'b0;
    check("f_pend_kept", 32'(pending), 4);
    check("f_drop_kept", 32'(dropped), 2);
    for (int k = 0; k < 3; k++) begin
      check("f_opd", 32'(add_opd), 32'(8 + k));
      add_ack = 1'b1;
      step();
    end
    add_ack = 1'b0;
    check("f_last", 32'(add_opd), 11);

    // overflow locks; detents then count as drops
    add_ack = 1'b1; add_ovf = 1'b1;
    step();
    add_ack = 1'b0; add_ovf = 1'b0;
    check("o_locked", 32'(locked), 1);
    check("o_req", 32'(add_req), 0);
    check("o_pend", 32'(pending), 0);
    for (int i = 0; i < 3; i++) begin
      rot_event = 1'b1;
      step();
    end
    rot_event = 1'b0;
    check("o_drop", 32'(dropped), 5);
    clr = 1'b1;
    step(); clr = 1'b0;
    check("c_accclr", 32'(acc_clr), 1);
    check("c_flags", 32'({locked, timeout}), 0);
    check("c_drop", 32'(dropped), 0);
    check("c_req", 32'(add_req), 0);
    step();
    check("c_accclr_end", 32'(acc_clr), 0);

    // stalled adder: req high for 15 cycles then timeout
    rot_event = 1'b1; rot_dir = 1'b0; y = 4'd3;
    step(); rot_event = 1'b0;
    repeat (14) step();
    check("t_req15", 32'(add_req), 1);
    check("t_to15", 32'(timeout), 0);
    step();
    check("t_to", 32'(timeout), 1);
    check("t_req", 32'(add_req), 0);
    check("t_pend", 32'(pending), 1);
    check("t_lock", 32'(locked), 0);
    clr = 1'b1; add_ack = 1'b1; rot_event = 1'b1;
    step();
    clr = 1'b0; add_ack = 1'b0; rot_event = 1'b0;
    check("t_clr_pend", 32'(pending), 0);
    check("t_clr_to", 32'(timeout), 0);
    check("t_clr_acc", 32'(acc_clr), 1);
    step();
    check("t_idle", 32'(add_req), 0);

    // drop counter saturates
    rot_event = 1'b1; rot_dir = 1'b1; y = 4'd1;
    step(); rot_event = 1'b0;
    add_ack = 1'b1; add_ovf = 1'b1;
    step();
    add_ack = 1'b0; add_ovf = 1'b0;
    check("sat_lock", 32'(locked), 1);
    rot_event = 1'b1;
    repeat (260) step();
    rot_event = 1'b0;
    check("sat_drop", 32'(dropped), 255);
    clr = 1'b1;
    step(); clr = 1'b0;
    check("sat_clr", 32'(dropped), 0);

    // async reset while a request is outstanding
    rot_event = 1'b1; y = 4'd9;
    step(); rot_event = 1'b0;
    check("r_req", 32'(add_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_req_drop", 32'(add_req), 0);
    check("r_pend", 32'(pending), 0);
    check("r_opd", 32'(add_opd), 0);
    step();
    check("r_hold", 32'({add_req, locked, timeout, acc_clr}), 0);
    rst_n = 1'b1;
    step();
    check("r_after", 32'(add_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
